stream_slot_scheduler: RTL
==========================

# stream_slot_scheduler

Transmit-side scheduler for the framed serial link that the stream syncer receives. It emits a continuous bit stream of fixed-length frames, each starting with the sync pattern, and time-shares the payload word slots between up to `N_REQ` requesters using round-robin arbitration. It sits between the word-producing clients and the serial line, and produces exactly the framing the syncer locks onto.

## Interface
- `PATTERN_SZ`, 8, sync pattern length in bits
- `PATTERN`, 8'b10110011, sync pattern, sent MSB first
- `WINDOW_SZ`, 32, frame length in bits, including the pattern
- `OUT_SZ`, 8, payload word width
- `N_REQ`, 4, number of requesters (≥1)
- `IDLE_WORD`, 0, word sent in an unclaimed slot
- Derived: `N_SLOT = (WINDOW_SZ-PATTERN_SZ)/OUT_SZ` (≥1 required); slot k starts at position `s_k = PATTERN_SZ + k*OUT_SZ`; the pad region runs from `PATTERN_SZ+N_SLOT*OUT_SZ` to `WINDOW_SZ-1`.
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: run enable.
- `req` in N_REQ: per-requester word-pending flag.
- `data` in N_REQ*OUT_SZ: requester i's word is at `[i*OUT_SZ +: OUT_SZ]`.
- `gnt` out N_REQ: one-hot, single-cycle grant. The word is consumed on that edge.
- `stream` out 1: serial output bit (registered).
- `frame_start` out 1: high while `stream` carries frame bit 0.
- `slot_valid` out 1: high while `stream` carries a granted word's bits.
- `slot_owner` out $clog2(N_REQ) (min 1): index of the requester owning the current slot. Holds 0 when `slot_valid`=0.

## Operation
- Frame position counter `pos` runs 0..WINDOW_SZ-1 and wraps to 0. It advances every cycle while running.
- Frame content at `pos`:
  - `pos` < PATTERN_SZ: `PATTERN` bits, MSB first.
  - Slot k: the selected word, MSB first.
  - Pad region: zeros.
- States:
  - IDLE to RUN when `en`=1, sampled with `pos`=0. The first RUN cycle outputs `PATTERN` MSB.
  - RUN to IDLE only at frame end: `en`=0 sampled in the cycle with `pos`=WINDOW_SZ-1. Frames are never truncated. `en` dropping mid-frame is ignored until frame end.
- In IDLE: `pos`=0, `stream`=0, all other outputs are 0, no grants are issued.
- Arbitration for slot k happens in the cycle with `pos`=s_k-1 (RUN only):
  - Round-robin over requesters with `req`=1 in that cycle, starting at pointer+1 mod N_REQ.
  - Winner i: `gnt[i]`=1 for that cycle; `data` word i is captured at the ending edge; the pointer is set to i.
  - No requester: slot carries `IDLE_WORD`, `slot_valid`=0, pointer unchanged.
- `req`/`data` are sampled only in arbitration cycles. A requester must hold both stable until granted. Deasserting `req` before the grant withdraws it with no side effect.
- One requester may win consecutive slots only if no other requester is pending.

## Timing
- Reset (async assert, `reset`=0): state IDLE, `pos`=0, pointer=N_REQ-1 (so requester 0 wins first). `stream`, `frame_start`, `slot_valid`, `slot_owner` and `gnt` are all 0.
- Reset deassertion is synchronous to `clk`. Reset mid-frame aborts the frame immediately, and the next frame restarts from the pattern.
- Grant-to-line latency: `gnt[i]` in the cycle with `pos`=s_k-1. The word MSB appears on `stream` the next cycle (`pos`=s_k), and the word LSB at `pos`=s_k+OUT_SZ-1.
- `slot_valid` and `slot_owner` are aligned to the same cycles as the slot's bits on `stream`.
- `frame_start`, `slot_valid` and `slot_owner` are registered and aligned with `stream`.
- Throughput: at most one word per slot and `N_SLOT` words per frame. Payload efficiency is N_SLOT*OUT_SZ/WINDOW_SZ.
- `gnt` is never asserted in IDLE, in the pattern region, or in the pad region. It is never multi-hot.

## Test plan
- Reset, then `en`=1 with no requests: the frame is 10110011 followed by 24 zeros, repeating every 32 cycles. `frame_start` pulses every 32 cycles. `gnt` and `slot_valid` stay 0.
- Requester 2 alone with `req`=1, `data`=8'hC3: `gnt[2]` at pos 7, 15 and 23. Each slot shows 11000011 on `stream`, with `slot_valid`=1 and `slot_owner`=2.
- All 4 requesters continuously pending with distinct words: grant order is 0,1,2 in frame 1, then 3,0,1 in frame 2. Each granted word is serialized MSB first in its slot.
- `en` deasserted at pos 12: the frame completes through pos 31, then `stream`=0 and there are no grants. Reasserting `en` restarts with pattern MSB at the next `pos`=0.
- `req[1]` raised at pos 8 and dropped at pos 14: no grant in slot 1. `req[1]` held through pos 15: `gnt[1]` at pos 15.
- Async `reset` pulse at pos 20: all outputs are 0 immediately. After release with `en`=1, a new frame starts with the pattern, and requester 0 has first priority.

Source files
------------

// File: rtl/stream_slot_scheduler.sv
// Transmit-side framing scheduler: emits sync pattern plus round-robin payload slots
// as a continuous serial bit stream with registered, stream-aligned side-band flags.
module stream_slot_scheduler #(
    parameter int                    PATTERN_SZ = 8,
    parameter logic [PATTERN_SZ-1:0] PATTERN    = 8'b10110011,
    parameter int                    WINDOW_SZ  = 32,
    parameter int                    OUT_SZ     = 8,
    parameter int                    N_REQ      = 4,
    parameter logic [OUT_SZ-1:0]     IDLE_WORD  = '0,
    localparam int                   OWNER_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*OUT_SZ-1:0]   data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      stream,
    output logic                      frame_start,
    output logic                      slot_valid,
    output logic [OWNER_W-1:0]        slot_owner
);

    localparam int N_SLOT   = (WINDOW_SZ - PATTERN_SZ) / OUT_SZ;
    localparam int SLOT_END = PATTERN_SZ + N_SLOT * OUT_SZ;
    localparam int POS_W    = (WINDOW_SZ > 1) ? $clog2(WINDOW_SZ) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WINDOW_SZ - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic [OWNER_W-1:0]    ptr_q;
    logic [OWNER_W-1:0]    winner;
    logic                  win_found;
    logic                  arb_cycle;
    logic [OUT_SZ-1:0]     win_word;
    logic [OUT_SZ-1:0]     word_q, word_d;
    logic [PATTERN_SZ-1:0] pattern_shifted;
    logic                  stream_d, frame_start_d, slot_valid_d;
    logic [OWNER_W-1:0]    slot_owner_d;

    // Arbitration happens one cycle before each slot's first bit, so the captured
    // word's MSB lands on the registered stream exactly at the slot start.
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        arb_cycle = 1'b0;
        if (state_q == RUN) begin
            for (int k = 0; k < N_SLOT; k++) begin
                if (int'(pos_q) == PATTERN_SZ + k * OUT_SZ - 1) arb_cycle = 1'b1;
            end
        end
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!win_found && req[i] && i == (int'(ptr_q) + off) % N_REQ) begin
                    win_found = 1'b1;
                    winner    = OWNER_W'(i);
                end
            end
        end
    end

    always_comb begin
        gnt      = '0;
        win_word = IDLE_WORD;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_cycle && win_found && winner == OWNER_W'(i)) begin
                gnt[i]   = 1'b1;
                win_word = data[i*OUT_SZ +: OUT_SZ];
            end
        end
    end

    // Outputs are computed for the next position so the registered line stays aligned with pos.
    always_comb begin
        state_d         = state_q;
        pos_d           = '0;
        word_d          = word_q;
        stream_d        = 1'b0;
        frame_start_d   = 1'b0;
        slot_valid_d    = 1'b0;
        slot_owner_d    = '0;

        case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN: begin
                if (pos_q == POS_LAST) begin
                    if (!en) state_d = IDLE;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        pattern_shifted = PATTERN << pos_d;

        if (state_d == RUN) begin
            frame_start_d = (pos_d == '0);
            if (int'(pos_d) < PATTERN_SZ) begin
                stream_d = pattern_shifted[PATTERN_SZ-1];
            end else if (arb_cycle) begin
                word_d       = win_word;
                stream_d     = win_word[OUT_SZ-1];
                slot_valid_d = win_found;
                slot_owner_d = win_found ? winner : '0;
            end else if (int'(pos_d) < SLOT_END) begin
                word_d       = word_q << 1;
                stream_d     = word_d[OUT_SZ-1];
                slot_valid_d = slot_valid;
                slot_owner_d = slot_owner;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            ptr_q       <= OWNER_W'(N_REQ - 1);
            word_q      <= '0;
            stream      <= 1'b0;
            frame_start <= 1'b0;
            slot_valid  <= 1'b0;
            slot_owner  <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            word_q      <= word_d;
            stream      <= stream_d;
            frame_start <= frame_start_d;
            slot_valid  <= slot_valid_d;
            slot_owner  <= slot_owner_d;
            if (arb_cycle && win_found) ptr_q <= winner;
        end
    end

endmodule
